// File: rtl/mem_master.sv
// mem_master: single-outstanding CPU load/store master for a word-wide RAM
// with a registered read port. Handles big-endian byte/half/word accesses.
// Sub-word stores are done as read-modify-write. Misaligned or out-of-range
// requests are rejected with an error response.
module mem_master #(
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_wr_en,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rd_ack
);

  typedef enum logic [1:0] {IDLE, READ, DATA, WRITE} state_t;

  // Only the bits that are used later are kept. The word-store data goes
  // straight into r_mem_wdata, so only the low half of wdata is needed for merges.
  typedef struct packed {
    logic                     we;
    logic [1:0]               size;
    logic                     sgn;
    logic [RAM_ADDR_BITS+1:0] addr;
    logic [15:0]              wd;
  } req_t;

  state_t      r_state, w_next;
  req_t        r_req;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata, r_mem_wdata;
  logic        w_accept, w_bad, w_word_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data, w_merged;

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_word_store = req_we && (req_size == 2'b10);
  // Reject illegal size, misalignment, or any address bit above the RAM.
  assign w_bad = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              || ((req_addr >> (RAM_ADDR_BITS + 2)) != 32'd0);

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    w_byte = mem_rdata[31:24];
    case (r_req.addr[1:0])
      2'd0: w_byte = mem_rdata[31:24];
      2'd1: w_byte = mem_rdata[23:16];
      2'd2: w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_req.addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  // Extend the selected byte or half to 32 bits. A word load passes through.
  always_comb begin
    w_load_data = mem_rdata;
    case (r_req.size)
      2'b00:   w_load_data = {{24{r_req.sgn & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_req.sgn & w_half[15]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Insert the right-justified store data into its lane of the read word.
  always_comb begin
    w_merged = mem_rdata;
    if (r_req.size == 2'b00) begin
      case (r_req.addr[1:0])
        2'd0: w_merged[31:24] = r_req.wd[7:0];
        2'd1: w_merged[23:16] = r_req.wd[7:0];
        2'd2: w_merged[15:8]  = r_req.wd[7:0];
        default: w_merged[7:0] = r_req.wd[7:0];
      endcase
    end else if (r_req.addr[1]) begin
      w_merged[15:0] = r_req.wd;
    end else begin
      w_merged[31:16] = r_req.wd;
    end
  end

  // State register. Reset drops straight to IDLE, which aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and RAM-side controls. The RAM address is driven only while busy.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !w_bad) w_next = w_word_store ? WRITE : READ;
      end
      READ: begin
        mem_addr = r_req.addr[RAM_ADDR_BITS+1:2];
        w_next   = DATA;
      end
      DATA: begin
        mem_addr = r_req.addr[RAM_ADDR_BITS+1:2];
        if (mem_rd_ack) w_next = r_req.we ? WRITE : IDLE;
      end
      WRITE: begin
        mem_addr  = r_req.addr[RAM_ADDR_BITS+1:2];
        mem_wr_en = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch, write-data staging and the one-cycle response pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_req <= '{we: req_we, size: req_size, sgn: req_signed,
                   addr: req_addr[RAM_ADDR_BITS+1:0], wd: req_wdata[15:0]};
        if (w_bad) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
        end else if (w_word_store) begin
          r_mem_wdata <= req_wdata;
        end
      end
      if ((r_state == DATA) && mem_rd_ack) begin
        if (r_req.we) begin
          r_mem_wdata <= w_merged;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load_data;
        end
      end
      if (r_state == WRITE) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter RAM_ADDR_BITS, default 10, word-address width of attached RAM.
REQ-002 SHALL have ports (clock and reset first; directions relative to mem_master):
  clk  input  1  single clock; all state updates on rising edge.
  reset  input  1  asynchronous, active-high reset.
  req_valid  input  1  CPU request present.
  req_ready  output  1  request accepted this edge when req_valid&&req_ready.
  req_we  input  1  1=store, 0=load.
  req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
  req_signed  input  1  loads: 1 sign-extend, 0 zero-extend.
  req_addr  input  32  byte address.
  req_wdata  input  32  store data, sub-word right-justified.
  resp_valid  output  1  one-cycle completion pulse.
  resp_rdata  output  32  load result; 0 for stores and errors.
  resp_err  output  1  qualifies resp_valid; access rejected.
  mem_wr_en  output  1  RAM write enable.
  mem_addr  output  RAM_ADDR_BITS  RAM word address.
  mem_wdata  output  32  RAM write data.
  mem_rdata  input  32  RAM read data, registered one edge after mem_addr.
  mem_rd_ack  input  1  RAM read-data-valid qualifier.

Function
REQ-003 SHALL implement states IDLE, READ, DATA, WRITE; req_ready=1 only in IDLE.
REQ-004 SHALL latch req_we/req_size/req_signed/req_addr/req_wdata on acceptance; inputs ignored otherwise.
REQ-005 SHALL check on acceptance: req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:RAM_ADDR_BITS+2]!=0 -> no RAM access, stay IDLE, resp_valid=1 and resp_err=1 next cycle.
REQ-006 SHALL drive mem_addr=latched addr[RAM_ADDR_BITS+1:2] in READ, DATA, WRITE; mem_wr_en=1 only in WRITE.
REQ-007 Load: IDLE->READ->DATA; in DATA, if mem_rd_ack=1 then capture mem_rdata, pulse resp_valid with extracted data, ->IDLE; if mem_rd_ack=0 remain in DATA.
REQ-008 Load latency: resp_valid high in the 3rd cycle after the accepting edge when mem_rd_ack=1.
REQ-009 Byte order SHALL be big-endian: byte offset 0 = bits[31:24], 3 = bits[7:0]; half offset 0 = bits[31:16].
REQ-010 Load extension per req_signed from bit 7 (byte) or bit 15 (half); word ignores req_signed.
REQ-011 Word store: IDLE->WRITE, mem_wdata=req_wdata; after WRITE edge pulse resp_valid, resp_err=0, ->IDLE (latency 2 cycles).
REQ-012 Sub-word store: IDLE->READ->DATA->WRITE (read-modify-write); DATA merges right-justified req_wdata into addressed lane of mem_rdata, other lanes unchanged; DATA waits on mem_rd_ack as REQ-007.
REQ-013 resp_valid SHALL be exactly one cycle per accepted request, never two requests outstanding.
REQ-014 A new request MAY be accepted in the same cycle resp_valid is high (back-to-back).
REQ-015 resp_rdata/resp_err SHALL hold last value while resp_valid=0.

Reset
REQ-016 reset SHALL asynchronously force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-017 reset mid-operation SHALL abort the pending request with no response; mem_wr_en deasserts immediately, a sub-word store in READ/DATA leaves RAM unmodified.

Verification
REQ-018 RAM word 4=0x8899AABB; load byte signed addr 0x11 -> resp_rdata=0xFFFFFF99 in 3rd cycle, resp_err=0.
REQ-019 Same RAM; load half unsigned addr 0x12 -> 0x0000AABB; load word 0x10 -> 0x8899AABB.
REQ-020 Store byte addr 0x13 wdata 0x000000CC -> states READ,DATA,WRITE, mem_wdata=0x8899AACC, word 4 reads back 0x8899AACC.
REQ-021 Load word addr 0x12; size 11; addr 0x00001000 with RAM_ADDR_BITS=10 -> resp_err=1, resp_rdata=0, mem_wr_en never 1.
REQ-022 Hold mem_rd_ack=0 for 3 cycles during load -> remains DATA, resp_valid only after ack returns; reset asserted during WRITE of a word store -> mem_wr_en=0 same cycle, no resp_valid.
REQ-023 Back-to-back: second request held valid during first resp_valid -> accepted that edge, two resp_valid pulses, correct order.
